// File: rtl/instruction_fetch.sv
// -----------------------------------------------------------------------------
// instruction_fetch
//   Fetch stage of a single-cycle datapath. It owns the program counter and an
//   internal instruction memory, which is written through a load port after
//   reset. It also computes the next PC, including PC-relative branches.
//   Opcode 2'b10 is HALT and freezes fetch until Reset.
//
// Ports
//   Clk          : clock; all state changes on the rising edge
//   Reset        : synchronous, active-high; returns to LOAD (memory kept)
//   Load_En      : memory write strobe, honoured only in LOAD
//   Load_Addr    : memory write address
//   Load_Data    : memory write data
//   Load_Done    : one-cycle pulse, LOAD -> RUN
//   Branch       : current instruction is a branch (from control unit)
//   Branch_Cond  : branch condition (from ALU/compare)
//   PC           : registered program counter
//   Instruction  : mem[PC] in RUN, 8'h80 (a harmless HALT word) otherwise
//   OpCode       : Instruction[7:6]
//   Instr_Valid  : high in RUN
//   Halted       : high in HALT
//   Instr_Count  : retired-instruction count, saturating at 16'hFFFF
// -----------------------------------------------------------------------------
module instruction_fetch #(
  parameter int PC_WIDTH = 8
) (
  input  logic                Clk,
  input  logic                Reset,
  input  logic                Load_En,
  input  logic [PC_WIDTH-1:0] Load_Addr,
  input  logic [7:0]          Load_Data,
  input  logic                Load_Done,
  input  logic                Branch,
  input  logic                Branch_Cond,
  output logic [PC_WIDTH-1:0] PC,
  output logic [7:0]          Instruction,
  output logic [1:0]          OpCode,
  output logic                Instr_Valid,
  output logic                Halted,
  output logic [15:0]         Instr_Count
);

  localparam int         Depth     = 1 << PC_WIDTH;
  localparam logic [7:0] IdleInstr = 8'h80;
  localparam logic [1:0] OpHalt    = 2'b10;

  typedef enum logic [1:0] {
    S_LOAD,
    S_RUN,
    S_HALT
  } state_t;

  state_t              state_q, state_d;
  logic [PC_WIDTH-1:0] pc_q, pc_d;
  logic [15:0]         count_q, count_d;
  logic [7:0]          mem [Depth];
  logic [7:0]          fetched;
  logic signed [5:0]   offset;
  logic                mem_we;

  // Asynchronous read. A word written in cycle N is visible in cycle N+1.
  assign fetched = mem[pc_q];
  assign offset  = fetched[5:0];

  // Reset outranks the load port, even inside LOAD.
  assign mem_we = (state_q == S_LOAD) && Load_En && !Reset;

  // NOTE: the program memory has no reset. Clearing it would need one write
  // per word, and a reset followed by Load_Done must re-run the resident
  // program.
  always_ff @(posedge Clk) begin
    if (mem_we) mem[Load_Addr] <= Load_Data;
  end

  // NOTE: state registers use non-blocking assignments so that every register
  // samples the pre-edge values. Reset is synchronous and has top priority.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q <= S_LOAD;
      pc_q    <= '0;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      count_q <= count_d;
    end
  end

  // NOTE: every output of this block is given a default before the case.
  // Paths that do not assign it then keep its value instead of inferring a
  // latch.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    count_d = count_q;
    case (state_q)
      S_LOAD: begin
        pc_d = '0;
        if (Load_Done) state_d = S_RUN;
      end
      S_RUN: begin
        // The halt instruction retires too, so the count advances for it.
        if (count_q != 16'hFFFF) count_d = count_q + 16'd1;
        if (fetched[7:6] == OpHalt) begin
          // PC stays on the halt word, and Branch is ignored.
          state_d = S_HALT;
        end else if (Branch && Branch_Cond) begin
          // The signed cast sign-extends the 6-bit offset. The sum wraps
          // modulo 2^PC_WIDTH, and an offset of -1 gives a self-loop.
          pc_d = pc_q + PC_WIDTH'(1) + PC_WIDTH'(offset);
        end else begin
          pc_d = pc_q + PC_WIDTH'(1);
        end
      end
      S_HALT:  state_d = S_HALT;
      default: state_d = S_LOAD;
    endcase
  end

  assign PC          = pc_q;
  assign Instruction = (state_q == S_RUN) ? fetched : IdleInstr;
  assign OpCode      = Instruction[7:6];
  assign Instr_Valid = (state_q == S_RUN);
  assign Halted      = (state_q == S_HALT);
  assign Instr_Count = count_q;

endmodule

// File: tb/tb_instruction_fetch.sv
// -----------------------------------------------------------------------------
// tb_instruction_fetch
//   Self-checking bench for instruction_fetch (PC_WIDTH = 8). Each scenario
//   task pushes the expected output record for every cycle onto a scoreboard
//   queue. It then pops one record per cycle and compares it with the DUT
//   outputs, sampled 1 time unit after the rising edge.
// -----------------------------------------------------------------------------
module tb_instruction_fetch;

  logic       Clk = 1'b0;
  logic       Reset = 1'b0;
  logic       Load_En = 1'b0;
  logic [7:0] Load_Addr = '0;
  logic [7:0] Load_Data = '0;
  logic       Load_Done = 1'b0;
  logic       Branch = 1'b0;
  logic       Branch_Cond = 1'b0;
  logic [7:0] PC;
  logic [7:0] Instruction;
  logic [1:0] OpCode;
  logic       Instr_Valid;
  logic       Halted;
  logic [15:0] Instr_Count;

  int total  = 0;
  int passed = 0;

  typedef struct packed {
    logic [7:0]  pc;
    logic [7:0]  instr;
    logic [1:0]  op;
    logic        valid;
    logic        halted;
    logic [15:0] cnt;
  } obs_t;

  obs_t sb[$];

  instruction_fetch #(.PC_WIDTH(8)) dut (
    .Clk(Clk), .Reset(Reset), .Load_En(Load_En), .Load_Addr(Load_Addr),
    .Load_Data(Load_Data), .Load_Done(Load_Done), .Branch(Branch),
    .Branch_Cond(Branch_Cond), .PC(PC), .Instruction(Instruction),
    .OpCode(OpCode), .Instr_Valid(Instr_Valid), .Halted(Halted),
    .Instr_Count(Instr_Count)
  );

  always #5 Clk = ~Clk;

  initial begin
    #5_000_000;
    $display("FAIL watchdog: got no finish, want finish before time limit");
    $fatal(1, "watchdog expired");
  end

  // ---------------------------------------------------------------- helpers
  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  function automatic obs_t mk(input logic [7:0] pc, input logic [7:0] instr,
                              input logic valid, input logic halted,
                              input logic [15:0] cnt);
    obs_t o;
    o.pc = pc; o.instr = instr; o.op = instr[7:6];
    o.valid = valid; o.halted = halted; o.cnt = cnt;
    return o;
  endfunction

  function automatic obs_t now_obs();
    return {PC, Instruction, OpCode, Instr_Valid, Halted, Instr_Count};
  endfunction

  function automatic string fmt(input obs_t o);
    return $sformatf("pc=%0d instr=%02h op=%b valid=%b halted=%b cnt=%h",
                     o.pc, o.instr, o.op, o.valid, o.halted, o.cnt);
  endfunction

  task automatic do_reset();
    Reset = 1'b1;
    tick();
    Reset = 1'b0;
  endtask

  task automatic load_word(input logic [7:0] a, input logic [7:0] d);
    Load_En = 1'b1; Load_Addr = a; Load_Data = d;
    tick();
    Load_En = 1'b0;
  endtask

  task automatic start_run();
    Load_Done = 1'b1;
    tick();
    Load_Done = 1'b0;
  endtask

  // ------------------------------------------------------------------ tests
  task automatic test_reset();
    obs_t e, g;
    // Reset wins over a simultaneous Load_Done.
    Reset = 1'b1; Load_Done = 1'b1;
    sb.push_back(mk(8'd0, 8'h80, 1'b0, 1'b0, 16'd0));
    tick(); tick();
    Reset = 1'b0; Load_Done = 1'b0;
    e = sb.pop_front(); g = now_obs(); total++;
    if (g !== e) $display("FAIL reset: got %s want %s", fmt(g), fmt(e));
    else passed++;
  endtask

  task automatic test_load_run();
    obs_t e, g;
    logic [7:0] prog [3] = '{8'h01, 8'h42, 8'h80};
    do_reset();
    for (int i = 0; i < 3; i++) load_word(8'(i), prog[i]);
    start_run();
    for (int i = 0; i < 3; i++) sb.push_back(mk(8'(i), prog[i], 1'b1, 1'b0, 16'(i)));
    for (int i = 0; i < 11; i++) sb.push_back(mk(8'd2, 8'h80, 1'b0, 1'b1, 16'd3));
    for (int i = 0; i < 14; i++) begin
      e = sb.pop_front(); g = now_obs(); total++;
      if (g !== e) $display("FAIL load_run[%0d]: got %s want %s", i, fmt(g), fmt(e));
      else passed++;
      tick();
    end
  endtask

  task automatic test_branch();
    obs_t e, g;
    logic [7:0] pcs  [9] = '{8'd0, 8'd1, 8'd2, 8'd3, 8'd4, 8'd2, 8'd3, 8'd4, 8'd5};
    logic [7:0] ins  [9] = '{8'h00, 8'h00, 8'h00, 8'h00, 8'hFD, 8'h00, 8'h00, 8'hFD, 8'h80};
    logic       br   [9] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
    logic       cond [9] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    do_reset();
    for (int i = 0; i < 4; i++) load_word(8'(i), 8'h00);
    load_word(8'd4, 8'hFD);
    load_word(8'd5, 8'h80);
    start_run();
    for (int i = 0; i < 9; i++) sb.push_back(mk(pcs[i], ins[i], 1'b1, 1'b0, 16'(i)));
    sb.push_back(mk(8'd5, 8'h80, 1'b0, 1'b1, 16'd9));
    for (int i = 0; i < 10; i++) begin
      if (i < 9) begin Branch = br[i]; Branch_Cond = cond[i]; end
      e = sb.pop_front(); g = now_obs(); total++;
      if (g !== e) $display("FAIL branch[%0d]: got %s want %s", i, fmt(g), fmt(e));
      else passed++;
      tick();
    end
    Branch = 1'b0; Branch_Cond = 1'b0;
  endtask

  // Backward branch from 0 lands on 255. A non-branch at 255 wraps to 0.
  // A taken +10 branch at 250 lands on 5, where the halt word ignores Branch.
  // With poke set, the load port is driven in every RUN and HALT cycle.
  task automatic test_wrap(input bit do_load, input bit poke);
    obs_t e, g;
    logic [7:0] pcs [6] = '{8'd0, 8'd255, 8'd0, 8'd1, 8'd250, 8'd5};
    logic [7:0] ins [6] = '{8'h3E, 8'h00, 8'h3E, 8'h38, 8'hCA, 8'h80};
    logic       br  [6] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
    do_reset();
    if (do_load) begin
      load_word(8'd0, 8'h3E);   load_word(8'd255, 8'h00);
      load_word(8'd1, 8'h38);   load_word(8'd250, 8'hCA);
      load_word(8'd5, 8'h80);
    end
    start_run();
    for (int i = 0; i < 6; i++) sb.push_back(mk(pcs[i], ins[i], 1'b1, 1'b0, 16'(i)));
    for (int i = 0; i < 3; i++) sb.push_back(mk(8'd5, 8'h80, 1'b0, 1'b1, 16'd6));
    Branch_Cond = 1'b1;
    Load_Addr = 8'd0; Load_Data = 8'h80;
    for (int i = 0; i < 9; i++) begin
      Branch = (i < 6) ? br[i] : 1'b1;
      Load_En = poke; Load_Done = poke;
      e = sb.pop_front(); g = now_obs(); total++;
      if (g !== e) $display("FAIL wrap(load=%0b,poke=%0b)[%0d]: got %s want %s",
                            do_load, poke, i, fmt(g), fmt(e));
      else passed++;
      tick();
    end
    Branch = 1'b0; Branch_Cond = 1'b0; Load_En = 1'b0; Load_Done = 1'b0;
  endtask

  task automatic test_load_done_same();
    obs_t e, g;
    do_reset();
    Load_En = 1'b1; Load_Addr = 8'd0; Load_Data = 8'h80; Load_Done = 1'b1;
    tick();
    Load_En = 1'b0; Load_Done = 1'b0;
    sb.push_back(mk(8'd0, 8'h80, 1'b1, 1'b0, 16'd0));
    sb.push_back(mk(8'd0, 8'h80, 1'b0, 1'b1, 16'd1));
    for (int i = 0; i < 2; i++) begin
      e = sb.pop_front(); g = now_obs(); total++;
      if (g !== e) $display("FAIL load_done_same[%0d]: got %s want %s", i, fmt(g), fmt(e));
      else passed++;
      tick();
    end
  endtask

  task automatic test_reset_mid();
    obs_t e, g;
    do_reset();
    for (int i = 0; i < 8; i++) load_word(8'(i), 8'h00);
    load_word(8'd8, 8'h80);
    start_run();
    for (int i = 0; i < 8; i++) sb.push_back(mk(8'(i), 8'h00, 1'b1, 1'b0, 16'(i)));
    sb.push_back(mk(8'd0, 8'h80, 1'b0, 1'b0, 16'd0));
    for (int i = 0; i < 8; i++) sb.push_back(mk(8'(i), 8'h00, 1'b1, 1'b0, 16'(i)));
    sb.push_back(mk(8'd8, 8'h80, 1'b1, 1'b0, 16'd8));
    sb.push_back(mk(8'd8, 8'h80, 1'b0, 1'b1, 16'd9));
    for (int i = 0; i < 19; i++) begin
      e = sb.pop_front(); g = now_obs(); total++;
      if (g !== e) $display("FAIL reset_mid[%0d]: got %s want %s", i, fmt(g), fmt(e));
      else passed++;
      if (i == 7) begin
        do_reset();
      end else if (i == 8) begin
        start_run();
      end else begin
        tick();
      end
    end
  endtask

  task automatic test_saturation();
    obs_t e, g;
    do_reset();
    for (int i = 0; i < 4; i++) load_word(8'(i), 8'h00);
    load_word(8'd4, 8'h7F);
    Branch = 1'b1; Branch_Cond = 1'b1;
    start_run();
    for (int i = 0; i < 7; i++)
      sb.push_back(mk((i < 4) ? 8'(i) : 8'd4, (i < 4) ? 8'h00 : 8'h7F, 1'b1, 1'b0, 16'(i)));
    sb.push_back(mk(8'd4, 8'h7F, 1'b1, 1'b0, 16'hFFFE));
    sb.push_back(mk(8'd4, 8'h7F, 1'b1, 1'b0, 16'hFFFF));
    sb.push_back(mk(8'd4, 8'h7F, 1'b1, 1'b0, 16'hFFFF));
    for (int i = 0; i < 10; i++) begin
      e = sb.pop_front(); g = now_obs(); total++;
      if (g !== e) $display("FAIL saturation[%0d]: got %s want %s", i, fmt(g), fmt(e));
      else passed++;
      if (i == 6) begin
        for (int k = 0; k < 65534 - 6; k++) tick();
      end else if (i == 8) begin
        for (int k = 0; k < 5000; k++) tick();
      end else begin
        tick();
      end
    end
    Branch = 1'b0; Branch_Cond = 1'b0;
  endtask

  initial begin
    test_reset();
    test_load_run();
    test_branch();
    test_wrap(1'b1, 1'b0);
    test_wrap(1'b0, 1'b1);
    test_wrap(1'b0, 1'b0);
    test_load_done_same();
    test_reset_mid();
    test_saturation();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
